// File: rtl/dffrsnq_pkg.sv
// Shared definitions for the dffrsnq_pipe delay line: the per-edge operation
// encoding and the scan-chain length helper.
package dffrsnq_pkg;

    // One operation per clock edge, listed from highest to lowest priority.
    typedef enum logic [2:0] {
        OP_RESET   = 3'd0,
        OP_SET     = 3'd1,
        OP_SHIFT   = 3'd2,
        OP_CAPTURE = 3'd3,
        OP_HOLD    = 3'd4
    } op_e;

    // Total number of flops on the scan chain: each stage holds WIDTH data
    // bits plus one valid bit.
    function automatic int unsigned scan_len(input int unsigned width,
                                             input int unsigned depth);
        return depth * (width + 32'd1);
    endfunction

endpackage

// File: rtl/dffrsnq_stage.sv
// One pipeline stage: WIDTH data flops plus a valid flop. The stage also forms
// one link of the scan chain, in the order valid, data[0] .. data[WIDTH-1].
module dffrsnq_stage
    import dffrsnq_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] SET_VALUE = {WIDTH{1'b1}},
    parameter logic            SET_VALID = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  op_e              op_i,
    input  logic [WIDTH-1:0] prev_data_i,
    input  logic             prev_v_i,
    input  logic             si_i,
    output logic [WIDTH-1:0] data_o,
    output logic             v_o,
    output logic             so_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             v_q;
    logic             v_d;
    logic [WIDTH:0]   chain_s;
    logic [WIDTH:0]   shifted_s;

    // The chain view of the stage puts valid at bit 0 so that a left shift
    // moves valid into data[0] and data[WIDTH-1] out towards the next stage.
    assign chain_s   = {data_q, v_q};
    assign shifted_s = {chain_s[WIDTH-1:0], si_i};

    // Next-state selection for the broadcast operation.
    always_comb begin
        data_d = data_q;
        v_d    = v_q;
        case (op_i)
            OP_RESET: begin
                data_d = {WIDTH{1'b0}};
                v_d    = 1'b0;
            end
            OP_SET: begin
                data_d = SET_VALUE;
                v_d    = SET_VALID;
            end
            OP_SHIFT: begin
                data_d = shifted_s[WIDTH:1];
                v_d    = shifted_s[0];
            end
            OP_CAPTURE: begin
                data_d = prev_data_i;
                v_d    = prev_v_i;
            end
            OP_HOLD: begin
                data_d = data_q;
                v_d    = v_q;
            end
            default: begin
                // Unreachable encodings fall back to the safe cleared state.
                data_d = {WIDTH{1'b0}};
                v_d    = 1'b0;
            end
        endcase
    end

    // Stage flops; reset is also forced directly here so the cleared state
    // does not depend on the decoded operation alone.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q <= {WIDTH{1'b0}};
            v_q    <= 1'b0;
        end else begin
            data_q <= data_d;
            v_q    <= v_d;
        end
    end

    assign data_o = data_q;
    assign v_o    = v_q;
    assign so_o   = data_q[WIDTH-1];

endmodule

// File: rtl/dffrsnq_pipe.sv
// Multi-bit, multi-stage set/reset flop bank with per-stage valid, global
// capture enable, synchronous set and a full-length scan chain.
module dffrsnq_pipe
    import dffrsnq_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter int              DEPTH     = 2,
    parameter logic [WIDTH-1:0] SET_VALUE = {WIDTH{1'b1}},
    parameter logic            SET_VALID = 1'b0
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             SETN,
    input  logic             EN,
    input  logic             SE,
    input  logic             SI,
    input  logic [WIDTH-1:0] D,
    input  logic             DV,
    output logic [WIDTH-1:0] Q,
    output logic             QV,
    output logic             SO
);

    op_e              op_s;
    logic [WIDTH-1:0] stage_data_s [DEPTH];
    logic             stage_v_s    [DEPTH];
    logic             stage_so_s   [DEPTH];

    // Decode the control inputs once per cycle in strict priority order.
    always_comb begin
        op_s = OP_HOLD;
        if (!RN) begin
            op_s = OP_RESET;
        end else if (!SETN) begin
            op_s = OP_SET;
        end else if (SE) begin
            op_s = OP_SHIFT;
        end else if (EN) begin
            op_s = OP_CAPTURE;
        end else begin
            op_s = OP_HOLD;
        end
    end

    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        logic [WIDTH-1:0] prev_data_s;
        logic             prev_v_s;
        logic             prev_so_s;

        if (s == 0) begin : g_first
            assign prev_data_s = D;
            assign prev_v_s    = DV;
            assign prev_so_s   = SI;
        end else begin : g_next
            assign prev_data_s = stage_data_s[s-1];
            assign prev_v_s    = stage_v_s[s-1];
            assign prev_so_s   = stage_so_s[s-1];
        end

        dffrsnq_stage #(
            .WIDTH     (WIDTH),
            .SET_VALUE (SET_VALUE),
            .SET_VALID (SET_VALID)
        ) u_stage (
            .clk_i       (CLK),
            .rst_ni      (RN),
            .op_i        (op_s),
            .prev_data_i (prev_data_s),
            .prev_v_i    (prev_v_s),
            .si_i        (prev_so_s),
            .data_o      (stage_data_s[s]),
            .v_o         (stage_v_s[s]),
            .so_o        (stage_so_s[s])
        );
    end

    // Outputs are taken straight from the last stage's flops.
    assign Q  = stage_data_s[DEPTH-1];
    assign QV = stage_v_s[DEPTH-1];
    assign SO = stage_so_s[DEPTH-1];

endmodule
